// File: rtl/sc_lane_pkg.sv
//==============================================================================
// Module  : sc_lane_pkg
// Brief   : Shared constants and preset-table helper for the lane registers.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package sc_lane_pkg;

   localparam logic SC_LANE_DIR_LEFT  = 1'b0;
   localparam logic SC_LANE_DIR_RIGHT = 1'b1;

   // Upper bounds for the helper; a lane table must fit inside these.
   localparam int SC_LANE_MAX_WIDTH      = 64;
   localparam int SC_LANE_MAX_TABLE_BITS = 2048;

   function automatic logic [SC_LANE_MAX_WIDTH-1:0] sc_lane_preset_entry(
      input logic [SC_LANE_MAX_TABLE_BITS-1:0] tbl,
      input int unsigned                       width,
      input int unsigned                       idx
   );
      logic [SC_LANE_MAX_WIDTH-1:0] mask;
      mask = ~({SC_LANE_MAX_WIDTH{1'b1}} << width);
      return SC_LANE_MAX_WIDTH'(tbl >> (idx * width)) & mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sc_lane_prescaler.sv
//==============================================================================
// Module  : sc_lane_prescaler
// Brief   : Step-period counter producing the lane rotation tick.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module sc_lane_prescaler #(
   parameter int PERIOD_WIDTH = 24
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_restart,
   input  logic                    i_run,
   input  logic [PERIOD_WIDTH-1:0] i_period,
   output logic                    o_tick
);

   localparam logic [PERIOD_WIDTH-1:0] c_ONE = PERIOD_WIDTH'(1);

   logic [PERIOD_WIDTH-1:0] r_cnt;
   logic [PERIOD_WIDTH-1:0] w_last;

   // A zero period behaves as one; >= lets a shortened period fire at once.
   assign w_last = (i_period == '0) ? '0 : (i_period - c_ONE);
   assign o_tick = i_run && (r_cnt >= w_last);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart || !i_run || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sc_reg_lane.sv
//==============================================================================
// Module  : sc_reg_lane
// Brief   : Self-rotating Frogger lane register with preset load.
//           Optional cell probe enabled by defining SC_REGLANE_PROBE_EN.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module sc_reg_lane
   import sc_lane_pkg::*;
#(
   parameter int                                LANE_WIDTH   = 8,
   parameter int                                NUM_PRESETS  = 8,
   parameter logic [NUM_PRESETS*LANE_WIDTH-1:0] PRESET_TABLE = '0,
   parameter logic [LANE_WIDTH-1:0]             CLEAR_VALUE  = '0,
   parameter int                                PERIOD_WIDTH = 24,
   localparam int SEL_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1,
   localparam int IDX_W = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1
) (
   input  logic                    SC_RegLANE_CLOCK_50,
   input  logic                    SC_RegLANE_RESET_InHigh,
   input  logic                    SC_RegLANE_clear_InLow,
   input  logic                    SC_RegLANE_load_In,
   input  logic [SEL_W-1:0]        SC_RegLANE_presetSel_In,
   input  logic                    SC_RegLANE_run_In,
   input  logic                    SC_RegLANE_dir_In,
   input  logic [PERIOD_WIDTH-1:0] SC_RegLANE_period_In,
   output logic [LANE_WIDTH-1:0]   SC_RegLANE_data_OutBUS,
   output logic                    SC_RegLANE_step_Out
`ifdef SC_REGLANE_PROBE_EN
   ,
   input  logic [IDX_W-1:0]        SC_RegLANE_probeIdx_In,
   output logic                    SC_RegLANE_hit_Out
`endif
);

   localparam logic [SC_LANE_MAX_TABLE_BITS-1:0] c_TABLE =
      SC_LANE_MAX_TABLE_BITS'(PRESET_TABLE);

   logic [LANE_WIDTH-1:0] r_lane;
   logic                  r_step;
   logic                  w_tick;
   logic                  w_restart;
   logic [LANE_WIDTH-1:0] w_presets [NUM_PRESETS];
   logic [LANE_WIDTH-1:0] w_preset;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PRESETS; gi++) begin : g_preset
         assign w_presets[gi] =
            LANE_WIDTH'(sc_lane_preset_entry(c_TABLE, LANE_WIDTH, gi));
      end
   endgenerate

   // Unmatched selects (beyond the table) fall through to CLEAR_VALUE.
   always_comb begin
      w_preset = CLEAR_VALUE;
      for (int i = 0; i < NUM_PRESETS; i++) begin
         if (SC_RegLANE_presetSel_In == SEL_W'(i)) begin
            w_preset = w_presets[i];
         end
      end
   end

   assign w_restart = !SC_RegLANE_clear_InLow || SC_RegLANE_load_In;

   sc_lane_prescaler #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_prescaler (
      .i_clk     (SC_RegLANE_CLOCK_50),
      .i_rst     (SC_RegLANE_RESET_InHigh),
      .i_restart (w_restart),
      .i_run     (SC_RegLANE_run_In),
      .i_period  (SC_RegLANE_period_In),
      .o_tick    (w_tick)
   );

   always_ff @(posedge SC_RegLANE_CLOCK_50) begin
      if (SC_RegLANE_RESET_InHigh) begin
         r_lane <= '0;
         r_step <= 1'b0;
      end else begin
         r_step <= 1'b0;
         if (!SC_RegLANE_clear_InLow) begin
            r_lane <= CLEAR_VALUE;
         end else if (SC_RegLANE_load_In) begin
            r_lane <= w_preset;
         end else if (w_tick) begin
            r_step <= 1'b1;
            case (SC_RegLANE_dir_In)
               SC_LANE_DIR_LEFT:  r_lane <= {r_lane[LANE_WIDTH-2:0], r_lane[LANE_WIDTH-1]};
               SC_LANE_DIR_RIGHT: r_lane <= {r_lane[0], r_lane[LANE_WIDTH-1:1]};
            endcase
         end
      end
   end

   assign SC_RegLANE_data_OutBUS = r_lane;
   assign SC_RegLANE_step_Out    = r_step;

`ifdef SC_REGLANE_PROBE_EN
   logic r_hit;
   logic w_probe;

   always_comb begin
      w_probe = 1'b0;
      for (int i = 0; i < LANE_WIDTH; i++) begin
         if (SC_RegLANE_probeIdx_In == IDX_W'(i)) begin
            w_probe = r_lane[i];
         end
      end
   end

   always_ff @(posedge SC_RegLANE_CLOCK_50) begin
      if (SC_RegLANE_RESET_InHigh) begin
         r_hit <= 1'b0;
      end else begin
         r_hit <= w_probe;
      end
   end

   assign SC_RegLANE_hit_Out = r_hit;
`else
   // Without the probe the lane is observable only on data_OutBUS.
`endif

endmodule

`default_nettype wire
